div_iter: RTL and testbench
===========================

# div_iter

Iterative 32-bit signed integer divider for the processor's execute stage, sitting alongside the ALU and multiplier in the multdiv path. A one-cycle start pulse latches both operands. The block then runs one restoring-division step per clock and returns a truncated quotient with a single-cycle ready pulse. The pipeline stalls on the ready pulse, and divide-by-zero is reported through an exception flag.

## Interface
- WIDTH, 32, operand and result width; only 32 is supported.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ctrl_DIV  in  1  start pulse; operands are sampled on the same edge.
- data_operandA  in  32  dividend, two's complement.
- data_operandB  in  32  divisor, two's complement.
- data_result  out  32  quotient, two's complement, truncated toward zero.
- data_exception  out  1  set with the ready pulse when the divisor is zero.
- data_resultRDY  out  1  one-cycle pulse marking data_result/data_exception valid.
- data_remainder  out  32  remainder; present only with DIV_REMAINDER_EN.

## Operation
- States:
  - IDLE: waiting for ctrl_DIV.
  - RUN: 32 steps, 5-bit step counter 0..31.
  - FIX: sign correction.
  - DONE: ready pulse.
- Transitions:
  - IDLE --ctrl_DIV--> RUN, or DONE if data_operandB==0.
  - RUN --count==31--> FIX.
  - FIX --> DONE.
  - DONE --> IDLE, or RUN/DONE if ctrl_DIV is high in the same cycle.
- Load (start edge):
  - Latch sign bits sA=A[31] and sB=B[31].
  - Latch magnitudes |A| and |B| as 32-bit unsigned; |0x80000000| = 0x80000000.
  - Clear the 33-bit partial remainder and the counter.
- RUN step:
  - Shift {rem, quo} left by 1, bringing in the next dividend MSB.
  - Trial-subtract |B| at 33-bit width.
  - If the difference is non-negative, keep it and set quo[0]=1; otherwise restore.
- FIX:
  - Quotient is negated iff sA^sB.
  - Remainder is negated iff sA, so its sign follows the dividend.
  - Both are registered into the outputs.
- Overflow: 0x80000000 / 0xFFFFFFFF yields 0x80000000 with data_exception=0, the natural wrap.
- Divide-by-zero:
  - No iteration is performed.
  - data_result=0 and data_exception=1; data_remainder=data_operandA when present.
- ctrl_DIV while in RUN or FIX aborts the current operation and restarts with the new operands. No ready pulse is issued for the aborted operation.
- data_result, data_exception and data_remainder hold their values until the next result is written or reset.
- Reset:
  - State goes to IDLE; all outputs and internal registers clear to 0.
  - Any in-flight operation is discarded with no ready pulse.
  - Reset has priority over ctrl_DIV in the same cycle.

## Timing
- Edge 0: ctrl_DIV sampled high.
- Edges 1..32: the 32 division steps.
- Edge 33: FIX writes the outputs and asserts data_resultRDY.
- data_resultRDY is high for exactly one cycle, between edges 33 and 34.
- Latency is 33 cycles from the start edge to RDY high.
- Divide-by-zero: RDY is high between edges 1 and 2, a latency of 1.
- Back-to-back: ctrl_DIV in the RDY cycle is accepted. The new result arrives 33 cycles later and the RDY pulse is not extended.
- No combinational path exists from inputs to outputs; all outputs are registered.

## Configuration
- DIV_REMAINDER_EN defined:
  - The data_remainder port exists.
  - The remainder register is sign-fixed in FIX.
- DIV_REMAINDER_EN undefined:
  - The port is absent and no remainder output register is built.
  - The partial remainder is still used internally.
  - Quotient behaviour and timing are identical in both builds.

## Test plan
- A=100, B=7, start -> RDY exactly 33 cycles later; result=14, exception=0, remainder=2.
- A=-100 (0xFFFFFF9C), B=7 -> result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). A=100, B=-7 -> result=-14, remainder=2.
- A=5, B=0 -> RDY 1 cycle after start; result=0, exception=1, remainder=5.
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=0, remainder=0. A=0x7FFFFFFF, B=1 -> result=0x7FFFFFFF.
- Start 100/7, then at cycle 10 start 50/5 -> a single RDY, 33 cycles after the second start, with result=10.
- Start 100/7 and assert reset at cycle 20 -> no RDY ever appears; all outputs read 0. A new start then completes normally with result=14.

Source files
------------

// File: rtl/div_iter.sv
// Iterative 32-bit signed restoring divider for the multdiv path.
// Optional remainder output: define DIV_REMAINDER_EN.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state, nxt;

  logic             sa, sb, dz;
  logic [WIDTH-1:0] quo, mb, rem;
  logic [4:0]       cnt;
  logic             bzero, wr_fix, wr_dz;
  logic [WIDTH-1:0] abs_a, abs_b, quo_fix;
  logic [WIDTH:0]   rem_sh, diff;

  assign bzero = (data_operandB == '0);
  assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // 33-bit trial subtraction; diff[WIDTH] set means restore
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, mb};
  assign quo_fix = (sa ^ sb) ? -quo : quo;

`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] rem_fix;
  assign rem_fix = sa ? -rem : rem;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt    = state;
    wr_fix = 1'b0;
    wr_dz  = 1'b0;
    unique case (state)
      IDLE: nxt = IDLE;
      RUN:  if (cnt == 5'd31) nxt = FIX;
      FIX: begin
        nxt    = DONE;
        wr_fix = !ctrl_DIV;
      end
      DONE: begin
        nxt   = dz ? DONE : IDLE;
        wr_dz = dz && !ctrl_DIV;
      end
      default: nxt = IDLE;
    endcase
    if (ctrl_DIV) nxt = bzero ? DONE : RUN;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sa             <= 1'b0;
      sb             <= 1'b0;
      dz             <= 1'b0;
      quo            <= '0;
      mb             <= '0;
      rem            <= '0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= wr_fix | wr_dz;
      if (ctrl_DIV) begin
        sa  <= data_operandA[WIDTH-1];
        sb  <= data_operandB[WIDTH-1];
        quo <= abs_a;
        mb  <= abs_b;
        // divide-by-zero parks |A| so the remainder fix path returns A
        rem <= bzero ? abs_a : '0;
        cnt <= '0;
        dz  <= bzero;
      end else if (state == RUN) begin
        cnt <= cnt + 5'd1;
        quo <= {quo[WIDTH-2:0], !diff[WIDTH]};
        rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      end
      if (wr_fix) begin
        data_result    <= quo_fix;
        data_exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
        data_remainder <= rem_fix;
`endif
      end
      if (wr_dz) begin
        data_result    <= '0;
        data_exception <= 1'b1;
        dz             <= 1'b0;
`ifdef DIV_REMAINDER_EN
        data_remainder <= rem_fix;
`endif
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus
// random operands against a signed-arithmetic reference model.
module tb_div_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q, exp_r;
  logic        exp_e;
  int          seen;

  always #5 clock = ~clock;

  div_iter #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic, truncating division
  task automatic model(input logic [31:0] a, input logic [31:0] b);
    longint la, lb;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (lb == 0) begin
      exp_q = '0;
      exp_r = a;
      exp_e = 1'b1;
    end else begin
      exp_q = 32'(la / lb);
      exp_r = 32'(la % lb);
      exp_e = 1'b0;
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    model(a, b);
  endtask

  task automatic wait_rdy(input string tag, input bit chk_low);
    int n;
    int lat;
    n = 0;
    while (n < 60) begin
      @(posedge clock); #1;
      n++;
      if (data_resultRDY) break;
    end
    lat = exp_e ? 1 : 33;
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_q"}, data_result, exp_q);
    chk({tag, "_exc"}, {31'b0, data_exception}, {31'b0, exp_e});
`ifdef DIV_REMAINDER_EN
    chk({tag, "_rem"}, data_remainder, exp_r);
`endif
    if (chk_low) begin
      @(posedge clock); #1;
      chk({tag, "_pulse"}, {31'b0, data_resultRDY}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    int k;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_q", data_result, 32'd0);
    chk("rst_exc", {31'b0, data_exception}, 32'd0);
    chk("rst_rdy", {31'b0, data_resultRDY}, 32'd0);

    launch(32'd100, 32'd7);
    chk("q_100_7", 32'd14, exp_q);
    wait_rdy("p100_7", 1);
    launch(32'hFFFFFF9C, 32'd7);
    wait_rdy("n100_7", 1);
    launch(32'd100, 32'hFFFFFFF9);
    wait_rdy("p100_n7", 1);
    launch(32'd5, 32'd0);
    wait_rdy("div0", 1);
    launch(32'h80000000, 32'hFFFFFFFF);
    wait_rdy("ovf", 1);
    launch(32'h7FFFFFFF, 32'd1);
    wait_rdy("max_1", 1);
    launch(32'h80000000, 32'h80000000);
    wait_rdy("min_min", 1);

    // back-to-back start in the ready cycle
    launch(32'd100, 32'd7);
    wait_rdy("b2b_a", 0);
    launch(32'd50, 32'd5);
    chk("b2b_ext", {31'b0, data_resultRDY}, 32'd0);
    wait_rdy("b2b_b", 1);

    // abort: restart mid-run, only the second result appears
    launch(32'd100, 32'd7);
    seen = 0;
    repeat (9) begin
      @(posedge clock); #1;
      if (data_resultRDY) seen++;
    end
    launch(32'd50, 32'd5);
    chk("abort_q", exp_q, 32'd10);
    chk("abort_early", seen, 0);
    wait_rdy("abort", 1);

    // reset mid-run, with a divide-by-zero start competing on that edge
    launch(32'd100, 32'd7);
    repeat (19) @(posedge clock);
    #1;
    reset = 1'b1;
    ctrl_DIV = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd0;
    @(posedge clock); #1;
    reset = 1'b0;
    ctrl_DIV = 1'b0;
    chk("mrst_q", data_result, 32'd0);
    chk("mrst_exc", {31'b0, data_exception}, 32'd0);
`ifdef DIV_REMAINDER_EN
    chk("mrst_rem", data_remainder, 32'd0);
`endif
    seen = 0;
    repeat (50) begin
      @(posedge clock); #1;
      if (data_resultRDY) seen++;
    end
    chk("mrst_norly", seen, 0);
    launch(32'd100, 32'd7);
    wait_rdy("post_rst", 1);

    for (int i = 0; i < 24; i++) begin
      k  = $urandom_range(0, 9);
      ra = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 5000);
      if ($urandom_range(0, 3) == 0) ra = -ra;
      if (k == 0)      rb = 32'd0;
      else if (k < 6)  rb = $urandom_range(1, 300);
      else             rb = $urandom;
      if (k[0]) rb = -rb;
      launch(ra, rb);
      wait_rdy($sformatf("rnd%0d", i), 1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
